// File: rtl/csr_unit.sv
// ---------------------------------------------------------------------------
// csr_unit : machine-mode CSR file with counters, trap entry/exit, irq eval
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module csr_unit #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned HART_ID     = 0,
  parameter logic [63:0] MTVEC_RESET = 64'd0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             csr_en,
  input  logic [1:0]       csr_op,
  input  logic [4:0]       rs1,
  input  logic [11:0]      address,
  input  logic [WIDTH-1:0] data_w,
  output logic [WIDTH-1:0] data_r,
  output logic             illegal,
  input  logic             retire,
  input  logic             trap,
  input  logic [WIDTH-1:0] trap_cause,
  input  logic [WIDTH-1:0] trap_pc,
  input  logic [WIDTH-1:0] trap_val,
  input  logic             mret,
  input  logic             irq_ext,
  input  logic             irq_timer,
  input  logic             irq_sw,
  output logic             irq_pending,
  output logic [WIDTH-1:0] mtvec_out,
  output logic [WIDTH-1:0] mepc_out
);

  localparam bit             IS32        = (WIDTH == 32);
  localparam logic [1:0]     MXL         = IS32 ? 2'b01 : 2'b10;
  localparam logic [WIDTH-1:0] MISA_VAL  = {MXL, {(WIDTH-2){1'b0}}} | WIDTH'(12'h100);
  localparam logic [WIDTH-1:0] MIE_MASK  = WIDTH'(12'h888);
  localparam logic [WIDTH-1:0] MTVEC_MSK = ~WIDTH'(2'b10);
  localparam logic [WIDTH-1:0] MEPC_MSK  = ~WIDTH'(2'b11);

  logic             mstatus_mie_q, mstatus_mie_d;
  logic             mstatus_mpie_q, mstatus_mpie_d;
  logic [WIDTH-1:0] mie_q, mie_d;
  logic [WIDTH-1:0] mtvec_q, mtvec_d;
  logic [WIDTH-1:0] mscratch_q, mscratch_d;
  logic [WIDTH-1:0] mepc_q, mepc_d;
  logic [WIDTH-1:0] mcause_q, mcause_d;
  logic [WIDTH-1:0] mtval_q, mtval_d;
  logic [63:0]      mcycle_q, mcycle_d;
  logic [63:0]      minstret_q, minstret_d;

  logic [WIDTH-1:0] mip_val, mstatus_val, rd_val, wval;
  logic             hit, eff_we, we;

  assign mip_val     = WIDTH'({irq_ext, 3'b000, irq_timer, 3'b000, irq_sw, 3'b000});
  assign mstatus_val = WIDTH'({2'b11, 3'b000, mstatus_mpie_q, 3'b000, mstatus_mie_q, 3'b000});

  always_comb begin
    hit    = 1'b1;
    rd_val = '0;
    case (address)
      12'h300: rd_val = mstatus_val;
      12'h301: rd_val = MISA_VAL;
      12'h304: rd_val = mie_q;
      12'h305: rd_val = mtvec_q;
      12'h340: rd_val = mscratch_q;
      12'h341: rd_val = mepc_q;
      12'h342: rd_val = mcause_q;
      12'h343: rd_val = mtval_q;
      12'h344: rd_val = mip_val;
      12'hB00, 12'hC00: rd_val = WIDTH'(mcycle_q);
      12'hB02, 12'hC02: rd_val = WIDTH'(minstret_q);
      12'hB80, 12'hC80: begin hit = IS32; rd_val = IS32 ? WIDTH'(mcycle_q[63:32]) : '0; end
      12'hB82, 12'hC82: begin hit = IS32; rd_val = IS32 ? WIDTH'(minstret_q[63:32]) : '0; end
      12'hF14: rd_val = WIDTH'(HART_ID);
      default: hit = 1'b0;
    endcase
  end

  always_comb begin
    case (csr_op)
      2'b01:   wval = data_w;
      2'b10:   wval = rd_val | data_w;
      2'b11:   wval = rd_val & ~data_w;
      default: wval = rd_val;
    endcase
  end

  assign eff_we  = csr_en && (csr_op != 2'b00) && ((csr_op == 2'b01) || (rs1 != 5'd0));
  assign illegal = csr_en && (csr_op != 2'b00) && (!hit || (eff_we && (address[11:10] == 2'b11)));
  assign data_r  = illegal ? '0 : rd_val;
  // Trap and mret win over a CSR write in the same cycle; the write is dropped.
  assign we      = eff_we && !illegal && !trap && !mret;

  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_d          = mie_q;
    mtvec_d        = mtvec_q;
    mscratch_d     = mscratch_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    mtval_d        = mtval_q;
    mcycle_d       = mcycle_q + 64'd1;
    minstret_d     = minstret_q + {63'd0, retire};
    if (we) begin
      case (address)
        12'h300: begin mstatus_mie_d = wval[3]; mstatus_mpie_d = wval[7]; end
        12'h304: mie_d      = wval & MIE_MASK;
        12'h305: mtvec_d    = wval & MTVEC_MSK;
        12'h340: mscratch_d = wval;
        12'h341: mepc_d     = wval & MEPC_MSK;
        12'h342: mcause_d   = wval;
        12'h343: mtval_d    = wval;
        12'hB00: mcycle_d   = IS32 ? {mcycle_q[63:32], wval[31:0]} : 64'(wval);
        12'hB02: minstret_d = IS32 ? {minstret_q[63:32], wval[31:0]} : 64'(wval);
        12'hB80: mcycle_d   = {wval[31:0], mcycle_q[31:0]};
        12'hB82: minstret_d = {wval[31:0], minstret_q[31:0]};
        default: ;
      endcase
    end
    if (trap) begin
      mepc_d         = trap_pc & MEPC_MSK;
      mcause_d       = trap_cause;
      mtval_d        = trap_val;
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
    end else if (mret) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      mtvec_q        <= WIDTH'(MTVEC_RESET);
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
      mcycle_q       <= '0;
      minstret_q     <= '0;
    end else begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_q          <= mie_d;
      mtvec_q        <= mtvec_d;
      mscratch_q     <= mscratch_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      mtval_q        <= mtval_d;
      mcycle_q       <= mcycle_d;
      minstret_q     <= minstret_d;
    end
  end

  assign irq_pending = mstatus_mie_q && |(mip_val & mie_q);
  assign mtvec_out   = mtvec_q;
  assign mepc_out    = mepc_q;

endmodule

`default_nettype wire

// File: tb/tb_csr_unit.sv
// Scoreboard bench for csr_unit: stimulus queues expected values tagged with a cycle,
// a negedge monitor pops and compares them against the DUT outputs.
`default_nettype none

module tb_csr_unit;

  localparam int K_DATA = 0;
  localparam int K_ILL  = 1;
  localparam int K_IRQ  = 2;
  localparam int K_MEPC = 3;
  localparam int K_MTVC = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        csr_en = 1'b0;
  logic [1:0]  csr_op = 2'b00;
  logic [4:0]  rs1 = 5'd0;
  logic [11:0] address = 12'h000;
  logic [31:0] data_w = 32'd0;
  logic [31:0] data_r;
  logic        illegal;
  logic        retire = 1'b0;
  logic        trap = 1'b0;
  logic [31:0] trap_cause = 32'd0;
  logic [31:0] trap_pc = 32'd0;
  logic [31:0] trap_val = 32'd0;
  logic        mret = 1'b0;
  logic        irq_ext = 1'b0;
  logic        irq_timer = 1'b0;
  logic        irq_sw = 1'b0;
  logic        irq_pending;
  logic [31:0] mtvec_out;
  logic [31:0] mepc_out;

  csr_unit #(.WIDTH(32), .HART_ID(5), .MTVEC_RESET(64'h100)) dut (
    .clock(clock), .reset_n(reset_n), .csr_en(csr_en), .csr_op(csr_op), .rs1(rs1),
    .address(address), .data_w(data_w), .data_r(data_r), .illegal(illegal),
    .retire(retire), .trap(trap), .trap_cause(trap_cause), .trap_pc(trap_pc),
    .trap_val(trap_val), .mret(mret), .irq_ext(irq_ext), .irq_timer(irq_timer),
    .irq_sw(irq_sw), .irq_pending(irq_pending), .mtvec_out(mtvec_out), .mepc_out(mepc_out)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct packed {
    int          cyc;
    int          kind;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   rel_cyc = 0;

  function automatic string kname(input int k);
    case (k)
      K_DATA:  return "data_r";
      K_ILL:   return "illegal";
      K_IRQ:   return "irq_pending";
      K_MEPC:  return "mepc_out";
      default: return "mtvec_out";
    endcase
  endfunction

  task automatic chk(input int kind, input logic [31:0] v);
    exp_t e;
    e.cyc  = cyc;
    e.kind = kind;
    e.val  = v;
    sb.push_back(e);
  endtask

  always @(negedge clock) begin
    exp_t        e;
    logic [31:0] act;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      case (e.kind)
        K_DATA:  act = data_r;
        K_ILL:   act = {31'd0, illegal};
        K_IRQ:   act = {31'd0, irq_pending};
        K_MEPC:  act = mepc_out;
        default: act = mtvec_out;
      endcase
      n_checks++;
      if (e.cyc != cyc || act !== e.val) begin
        n_fail++;
        $display("FAIL %s (cycle %0d, addr 0x%03h): got 0x%08h, expected 0x%08h",
                 kname(e.kind), e.cyc, address, act, e.val);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic csr(input logic [1:0] op, input logic [4:0] r, input logic [11:0] a,
                     input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_ill);
    csr_en  = 1'b1;
    csr_op  = op;
    rs1     = r;
    address = a;
    data_w  = d;
    chk(K_DATA, exp_rd);
    chk(K_ILL, {31'd0, exp_ill});
    step();
    csr_en = 1'b0;
    csr_op = 2'b00;
    rs1    = 5'd0;
    data_w = 32'd0;
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] e);
    address = a;
    chk(K_DATA, e);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    step();
    step();
    // Reset values while reset_n is held low
    address = 12'h300;
    chk(K_DATA, 32'h1800);
    chk(K_MTVC, 32'h100);
    chk(K_MEPC, 32'h0);
    chk(K_IRQ, 32'h0);
    step();
    rd(12'h305, 32'h100);
    rd(12'hF14, 32'h5);
    rd(12'h301, 32'h4000_0100);
    reset_n = 1'b1;
    rel_cyc = cyc;
    rd(12'hB00, 32'd0);
    rd(12'hB00, 32'd1);
    rd(12'hB00, 32'd2);
    rd(12'hB00, 32'd3);

    // RW/RS/RC on mscratch; data_r shows the pre-write value
    csr(2'b01, 5'd1, 12'h340, 32'hA5A5_0000, 32'h0, 1'b0);
    csr(2'b10, 5'd1, 12'h340, 32'h0000_00FF, 32'hA5A5_0000, 1'b0);
    csr(2'b11, 5'd1, 12'h340, 32'hA500_0000, 32'hA5A5_00FF, 1'b0);
    rd(12'h340, 32'h00A5_00FF);

    // Illegal accesses and legal read-only reads
    csr(2'b01, 5'd3, 12'hC00, 32'h1234, 32'h0, 1'b1);
    csr(2'b10, 5'd0, 12'hC00, 32'hFFFF, 32'(cyc - rel_cyc), 1'b0);
    csr(2'b01, 5'd1, 12'h7C0, 32'h1, 32'h0, 1'b1);
    csr(2'b10, 5'd0, 12'h7C0, 32'h0, 32'h0, 1'b1);
    csr(2'b01, 5'd0, 12'hF14, 32'h0, 32'h0, 1'b1);
    csr(2'b11, 5'd0, 12'h301, 32'hFFFF_FFFF, 32'h4000_0100, 1'b0);

    // Interrupt enable and pending
    csr(2'b10, 5'd1, 12'h300, 32'h8, 32'h1800, 1'b0);
    csr(2'b01, 5'd1, 12'h304, 32'h80, 32'h0, 1'b0);
    address = 12'h344;
    chk(K_DATA, 32'h0);
    chk(K_IRQ, 32'h0);
    step();
    irq_timer = 1'b1;
    chk(K_DATA, 32'h80);
    chk(K_IRQ, 32'h1);
    step();

    // Trap entry
    trap = 1'b1; trap_pc = 32'h1003; trap_cause = 32'h8000_0007; trap_val = 32'h55;
    address = 12'h300;
    chk(K_DATA, 32'h1808);
    chk(K_IRQ, 32'h1);
    step();
    trap = 1'b0;
    chk(K_MEPC, 32'h1000);
    chk(K_IRQ, 32'h0);
    rd(12'h300, 32'h1880);
    rd(12'h342, 32'h8000_0007);
    rd(12'h343, 32'h55);
    rd(12'h341, 32'h1000);

    // Trap exit
    mret = 1'b1;
    address = 12'h300;
    chk(K_DATA, 32'h1880);
    step();
    mret = 1'b0;
    chk(K_IRQ, 32'h1);
    rd(12'h300, 32'h1888);
    irq_timer = 1'b0;
    chk(K_IRQ, 32'h0);
    step();

    // Trap wins over a same-cycle mepc write
    trap = 1'b1; trap_pc = 32'h3006; trap_cause = 32'h2; trap_val = 32'h0;
    csr(2'b01, 5'd1, 12'h341, 32'h2000, 32'h1000, 1'b0);
    trap = 1'b0;
    chk(K_MEPC, 32'h3004);
    rd(12'h300, 32'h1880);
    rd(12'h342, 32'h2);

    // mret wins over a same-cycle mscratch write
    mret = 1'b1;
    csr(2'b01, 5'd1, 12'h340, 32'h1111, 32'h00A5_00FF, 1'b0);
    mret = 1'b0;
    rd(12'h340, 32'h00A5_00FF);
    rd(12'h300, 32'h1888);

    // Forced-zero bits on mepc, mtvec and mie
    csr(2'b01, 5'd1, 12'h341, 32'h2003, 32'h3004, 1'b0);
    chk(K_MEPC, 32'h2000);
    rd(12'h341, 32'h2000);
    csr(2'b01, 5'd1, 12'h305, 32'h207, 32'h100, 1'b0);
    chk(K_MTVC, 32'h205);
    rd(12'h305, 32'h205);
    csr(2'b01, 5'd1, 12'h304, 32'hFFFF_FFFF, 32'h80, 1'b0);
    rd(12'h304, 32'h888);

    // mcycle low-half overflow carries into the high half
    csr(2'b01, 5'd1, 12'hB00, 32'hFFFF_FFFF, 32'(cyc - rel_cyc), 1'b0);
    csr(2'b01, 5'd1, 12'hB80, 32'h0, 32'h0, 1'b0);
    rd(12'hB00, 32'hFFFF_FFFF);
    rd(12'hB00, 32'h0);
    rd(12'hB80, 32'h1);
    rd(12'hC80, 32'h1);

    // minstret write suppresses the same-cycle retire increment
    retire = 1'b1;
    csr(2'b01, 5'd1, 12'hB02, 32'h10, 32'h0, 1'b0);
    rd(12'hB02, 32'h10);
    retire = 1'b0;
    rd(12'hB02, 32'h11);
    rd(12'hB82, 32'h0);
    rd(12'hC02, 32'h11);

    // Reset asserted mid-instruction discards the write
    csr_en = 1'b1; csr_op = 2'b01; rs1 = 5'd1; address = 12'h340; data_w = 32'hDEAD;
    #2;
    reset_n = 1'b0;
    chk(K_DATA, 32'h0);
    chk(K_MTVC, 32'h100);
    step();
    csr_en = 1'b0; csr_op = 2'b00; rs1 = 5'd0; data_w = 32'd0;
    reset_n = 1'b1;
    rd(12'h340, 32'h0);
    rd(12'h305, 32'h100);
    rd(12'h300, 32'h1800);

    step();
    step();
    if (sb.size() != 0) begin
      $display("FAIL scoreboard drain: got %0d pending entries, expected 0", sb.size());
      n_fail += sb.size();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
